// File: rtl/keypad_pkg.sv
// Shared types, one-hot constants and the column/row to hex key map
// for the 4x4 hex keypad scan controller.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HOLD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   localparam logic [3:0] ONE   = 4'b0001;
   localparam logic [3:0] TWO   = 4'b0010;
   localparam logic [3:0] THREE = 4'b0100;
   localparam logic [3:0] FOUR  = 4'b1000;

   // Hex code of the key at a one-hot column and one-hot row; 0 for illegal codes
   function automatic logic [3:0] key_map(input logic [3:0] col, input logic [3:0] row);
      logic [3:0] code;
      code = 4'h0;
      case (col)
         ONE: begin
            case (row)
               ONE:     code = 4'h1;
               TWO:     code = 4'h4;
               THREE:   code = 4'h7;
               FOUR:    code = 4'hE;
               default: code = 4'h0;
            endcase
         end
         TWO: begin
            case (row)
               ONE:     code = 4'h2;
               TWO:     code = 4'h5;
               THREE:   code = 4'h8;
               FOUR:    code = 4'h0;
               default: code = 4'h0;
            endcase
         end
         THREE: begin
            case (row)
               ONE:     code = 4'h3;
               TWO:     code = 4'h6;
               THREE:   code = 4'h9;
               FOUR:    code = 4'hF;
               default: code = 4'h0;
            endcase
         end
         FOUR: begin
            case (row)
               ONE:     code = 4'hA;
               TWO:     code = 4'hB;
               THREE:   code = 4'hC;
               FOUR:    code = 4'hD;
               default: code = 4'h0;
            endcase
         end
         default: code = 4'h0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider: tick is high for one clk every SCAN_DIV cycles.
module keypad_tick_gen #(
   parameter int SCAN_DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int W = $clog2(SCAN_DIV);

   logic [W-1:0] count;

   assign tick = (count == W'(SCAN_DIV - 1));

   // Count 0..SCAN_DIV-1 and wrap on the tick cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan sequencer and debouncer: rotates column strobes, synchronizes
// the row lines and accepts a single debounced key with a one-cycle strobe.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] rows_in,
   output logic [3:0] cols_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int CW = $clog2(DEBOUNCE_CNT + 1);

   logic         tick;
   logic [3:0]   rows_m;
   logic [3:0]   rows_s;
   state_t       state;
   state_t       state_next;
   logic [3:0]   col_next;
   logic [3:0]   row_lat;
   logic [3:0]   row_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic [CW-1:0] cnt_inc;
   logic [3:0]   code_next;
   logic         valid_next;
   logic         held_next;
   logic         rows_onehot;
   logic [3:0]   col_rotated;

   keypad_tick_gen #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign cnt_inc     = cnt + CW'(1);
   assign rows_onehot = $onehot(rows_s);
   assign col_rotated = {cols_out[2:0], cols_out[3]};

   // Two-flop synchronizer for the asynchronous row lines
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rows_m <= 4'b0000;
         rows_s <= 4'b0000;
      end else begin
         rows_m <= rows_in;
         rows_s <= rows_m;
      end
   end

   // Scan/debounce decisions, taken only on scan ticks
   always_comb begin
      state_next = state;
      col_next   = cols_out;
      row_next   = row_lat;
      cnt_next   = cnt;
      code_next  = key_code;
      valid_next = 1'b0;
      held_next  = key_held;
      if (tick) begin
         case (state)
            SCAN: begin
               if (rows_onehot) begin
                  row_next = rows_s;
                  if (DEBOUNCE_CNT == 1) begin
                     code_next  = key_map(cols_out, rows_s);
                     valid_next = 1'b1;
                     held_next  = 1'b1;
                     cnt_next   = '0;
                     state_next = HOLD;
                  end else begin
                     cnt_next   = CW'(1);
                     state_next = DEBOUNCE;
                  end
               end else begin
                  col_next = col_rotated;
               end
            end
            DEBOUNCE: begin
               if (rows_s == row_lat) begin
                  if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
                     code_next  = key_map(cols_out, row_lat);
                     valid_next = 1'b1;
                     held_next  = 1'b1;
                     cnt_next   = '0;
                     state_next = HOLD;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end else begin
                  cnt_next   = '0;
                  col_next   = col_rotated;
                  state_next = SCAN;
               end
            end
            HOLD: begin
               if (rows_s != row_lat) begin
                  cnt_next   = '0;
                  state_next = RELEASE;
               end
            end
            RELEASE: begin
               if (rows_s == 4'b0000) begin
                  if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
                     held_next  = 1'b0;
                     cnt_next   = '0;
                     col_next   = col_rotated;
                     state_next = SCAN;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end else begin
                  cnt_next = '0;
               end
            end
            default: begin
               state_next = SCAN;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // State, column strobe and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= SCAN;
         cols_out  <= ONE;
         row_lat   <= 4'b0000;
         cnt       <= '0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_next;
         cols_out  <= col_next;
         row_lat   <= row_next;
         cnt       <= cnt_next;
         key_code  <= code_next;
         key_valid <= valid_next;
         key_held  <= held_next;
      end
   end

endmodule
